// File: rtl/snake_dir_queue.sv
// Direction-command FIFO between button pulses and the snake game core.
// Optional feature macro: SNAKE_DIR_REVERSE_FILTER_EN (reject 180-degree reversals).
module snake_dir_queue #(
    parameter int DEPTH = 4
) (
    input  logic                       board_clk,
    input  logic                       reset,
    input  logic                       left,
    input  logic                       right,
    input  logic                       up,
    input  logic                       down,
    input  logic                       tick,
    input  logic                       flush,
    output logic [1:0]                 dir,
    output logic                       step,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       dropped
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [1:0] DIR_RIGHT = 2'b01;

    logic [1:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [1:0]    last_dir;

    logic [2:0]    press_cnt;
    logic          single;
    logic          multi;
    logic [1:0]    cand;
    logic          dup;
    logic          rev_reject;
    logic          full_block;
    logic          accept;
    logic          drop;
    logic          pop;
    logic [CW-1:0] count_next;

    // Encoding: up 00, right 01, down 10, left 11; opposite differs only in bit 1.
    always_comb begin
        press_cnt = {2'b00, left} + {2'b00, right} + {2'b00, up} + {2'b00, down};
        single    = (press_cnt == 3'd1);
        multi     = (press_cnt > 3'd1);
        cand      = 2'b00;
        if (right) cand = 2'b01;
        if (down)  cand = 2'b10;
        if (left)  cand = 2'b11;
    end

    always_comb begin
        dup = (cand == last_dir);
`ifdef SNAKE_DIR_REVERSE_FILTER_EN
        rev_reject = (cand == (last_dir ^ 2'b10));
`else
        rev_reject = 1'b0;
`endif
        full_block = full && !tick;
        accept     = !reset && !flush && single && !dup && !rev_reject && !full_block;
        drop       = multi || (single && !accept);
        pop        = tick && (count != '0);
    end

    always_comb begin
        count_next = count;
        case ({accept, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    // Storage needs no reset: count and pointers define which entries are live.
    always_ff @(posedge board_clk) begin
        if (accept)
            mem[wr_ptr] <= cand;
    end

    // A same-cycle write to the head slot (full with tick) still pops the old entry.
    always_ff @(posedge board_clk) begin
        if (reset || flush) begin
            dir      <= DIR_RIGHT;
            last_dir <= DIR_RIGHT;
            count    <= '0;
            full     <= 1'b0;
            step     <= 1'b0;
            dropped  <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            step    <= tick;
            dropped <= drop;
            count   <= count_next;
            full    <= (count_next == FULL_COUNT);
            if (accept) begin
                wr_ptr   <= wr_ptr + 1'b1;
                last_dir <= cand;
            end
            if (pop) begin
                dir    <= mem[rd_ptr];
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_snake_dir_queue.sv
// Self-checking bench for snake_dir_queue against a queue-based reference model.
module tb_snake_dir_queue;

    localparam int DEPTH = 4;
    localparam int CW = $clog2(DEPTH) + 1;

    logic          board_clk = 1'b0;
    logic          reset = 1'b0;
    logic          left = 1'b0, right = 1'b0, up = 1'b0, down = 1'b0;
    logic          tick = 1'b0, flush = 1'b0;
    logic [1:0]    dir;
    logic          step;
    logic [CW-1:0] count;
    logic          full;
    logic          dropped;

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [1:0]    q[$];
    logic [1:0]    m_dir, m_last;
    logic          m_step, m_dropped, m_full;
    logic [CW-1:0] m_count;

    snake_dir_queue #(.DEPTH(DEPTH)) dut (
        .board_clk(board_clk), .reset(reset),
        .left(left), .right(right), .up(up), .down(down),
        .tick(tick), .flush(flush),
        .dir(dir), .step(step), .count(count), .full(full), .dropped(dropped)
    );

    always #5 board_clk = ~board_clk;

    task automatic model_step(input logic l, r, u, d, t, f, rs);
        int n;
        int c;
        bit filt;
        bit acc;
        filt = 1'b0;
`ifdef SNAKE_DIR_REVERSE_FILTER_EN
        filt = 1'b1;
`endif
        if (rs || f) begin
            q.delete();
            m_dir = 2'd1; m_last = 2'd1; m_step = 0; m_dropped = 0;
        end else begin
            n = int'(l) + int'(r) + int'(u) + int'(d);
            c = u ? 0 : r ? 1 : d ? 2 : 3;
            acc = 0;
            m_dropped = 0;
            if (n > 1) m_dropped = 1;
            else if (n == 1) begin
                if (c == int'(m_last)) m_dropped = 1;
                else if (filt && c == (int'(m_last) + 2) % 4) m_dropped = 1;
                else if (q.size() == DEPTH && !t) m_dropped = 1;
                else acc = 1;
            end
            if (t && q.size() > 0) m_dir = q.pop_front();
            if (acc) begin
                q.push_back(2'(c));
                m_last = 2'(c);
            end
            m_step = t;
        end
        m_count = CW'(q.size());
        m_full  = (q.size() == DEPTH);
    endtask

    // Drives one cycle of inputs, updates the model at the edge, and samples #1 later.
    task automatic applyStimulus(input logic l, r, u, d, t, f, rs);
        left = l; right = r; up = u; down = d; tick = t; flush = f; reset = rs;
        @(posedge board_clk);
        model_step(l, r, u, d, t, f, rs);
        #1;
        left = 0; right = 0; up = 0; down = 0; tick = 0; flush = 0; reset = 0;
    endtask

    task automatic test_reset();
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        checks++;
        if ({dir, step, count, full, dropped} !== {2'b01, 1'b0, CW'(0), 1'b0, 1'b0}) begin
            failures++;
            $display("[TB] FAIL reset_state actual dir=%b step=%b count=%0d full=%b dropped=%b required 01/0/0/0/0",
                     dir, step, count, full, dropped);
        end
    endtask

    task automatic test_basic_pop();
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 1, 0, 0, 0, 0);
        checks++;
        if (count !== CW'(1) || dropped !== 1'b0) begin
            failures++;
            $display("[TB] FAIL basic_push actual count=%0d dropped=%b required 1/0", count, dropped);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        checks++;
        if ({dir, step, count, dropped} !== {2'b00, 1'b1, CW'(0), 1'b0}) begin
            failures++;
            $display("[TB] FAIL basic_pop actual dir=%b step=%b count=%0d dropped=%b required 00/1/0/0",
                     dir, step, count, dropped);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (step !== 1'b0) begin
            failures++;
            $display("[TB] FAIL basic_step_width actual=%b required=0", step);
        end
    endtask

    task automatic test_sequence();
        logic [1:0] exp_dirs [3];
        exp_dirs[0] = 2'b00; exp_dirs[1] = 2'b11; exp_dirs[2] = 2'b10;
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        checks++;
        if (count !== CW'(3)) begin
            failures++;
            $display("[TB] FAIL seq_count actual=%0d required=3", count);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 0, 1, 0, 0);
            checks++;
            if (dir !== exp_dirs[i] || step !== 1'b1) begin
                failures++;
                $display("[TB] FAIL seq_dir%0d actual dir=%b step=%b required dir=%b step=1",
                         i, dir, step, exp_dirs[i]);
            end
        end
        // last-accepted is now down; left makes it left, then right is a reversal
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        checks++;
`ifdef SNAKE_DIR_REVERSE_FILTER_EN
        if (dropped !== 1'b1 || count !== CW'(1)) begin
            failures++;
            $display("[TB] FAIL seq_reversal actual dropped=%b count=%0d required 1/1", dropped, count);
        end
`else
        if (dropped !== 1'b0 || count !== CW'(2)) begin
            failures++;
            $display("[TB] FAIL seq_reversal actual dropped=%b count=%0d required 0/2", dropped, count);
        end
`endif
    endtask

    task automatic test_full();
        logic [3:0] pat;
        for (int pass = 0; pass < 2; pass++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 1);
            for (int i = 0; i < 5; i++) begin
                pat = (i % 2 == 0) ? 4'b0010 : 4'b1000;
                applyStimulus(pat[3], pat[2], pat[1], pat[0], (pass == 1 && i == 4), 0, 0);
                if (i == 3) begin
                    checks++;
                    if (full !== 1'b1 || count !== CW'(4)) begin
                        failures++;
                        $display("[TB] FAIL full_after4 actual full=%b count=%0d required 1/4", full, count);
                    end
                end
            end
            checks++;
            if (pass == 0) begin
                if (dropped !== 1'b1 || count !== CW'(4)) begin
                    failures++;
                    $display("[TB] FAIL full_drop actual dropped=%b count=%0d required 1/4", dropped, count);
                end
            end else begin
                if (dropped !== 1'b0 || count !== CW'(4) || dir !== 2'b00 || full !== 1'b1) begin
                    failures++;
                    $display("[TB] FAIL full_tick_accept actual dropped=%b count=%0d dir=%b full=%b required 0/4/00/1",
                             dropped, count, dir, full);
                end
            end
        end
    endtask

    task automatic test_multi_press();
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        applyStimulus(1, 0, 1, 0, 0, 0, 0);
        checks++;
        if (dropped !== 1'b1 || count !== CW'(0)) begin
            failures++;
            $display("[TB] FAIL multi_press actual dropped=%b count=%0d required 1/0", dropped, count);
        end
        applyStimulus(0, 1, 0, 0, 0, 0, 0);
        checks++;
        if (dropped !== 1'b1 || count !== CW'(0)) begin
            failures++;
            $display("[TB] FAIL dup_at_reset actual dropped=%b count=%0d required 1/0", dropped, count);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (dropped !== 1'b0) begin
            failures++;
            $display("[TB] FAIL drop_width actual=%b required=0", dropped);
        end
    endtask

    task automatic test_flush();
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 1, 1, 0);
        checks++;
        if ({count, dir, dropped, step} !== {CW'(0), 2'b01, 1'b0, 1'b0}) begin
            failures++;
            $display("[TB] FAIL flush actual count=%0d dir=%b dropped=%b step=%b required 0/01/0/0",
                     count, dir, dropped, step);
        end
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        checks++;
        if (step !== 1'b1 || dir !== 2'b01) begin
            failures++;
            $display("[TB] FAIL flush_tick actual step=%b dir=%b required 1/01", step, dir);
        end
    endtask

    task automatic test_random();
        int sel;
        logic [3:0] pat;
        logic t, f;
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        for (int cyc = 0; cyc < 300; cyc++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                0: pat = 4'b1000;
                1: pat = 4'b0100;
                2: pat = 4'b0010;
                3: pat = 4'b0001;
                4: pat = 4'b1000;
                5: pat = 4'b0010;
                6: pat = 4'b1010;
                default: pat = 4'b0000;
            endcase
            t = ($urandom_range(0, 2) == 0);
            f = ($urandom_range(0, 60) == 0);
            if (cyc == 150) begin
                applyStimulus(pat[3], pat[2], pat[1], pat[0], 1'b1, 1'b0, 1'b1);
                checks++;
                if ({count, dir, step, dropped, full} !== {CW'(0), 2'b01, 1'b0, 1'b0, 1'b0}) begin
                    failures++;
                    $display("[TB] FAIL mid_reset actual count=%0d dir=%b step=%b dropped=%b full=%b required 0/01/0/0/0",
                             count, dir, step, dropped, full);
                end
            end else begin
                applyStimulus(pat[3], pat[2], pat[1], pat[0], t, f, 1'b0);
                checks++;
                if ({dir, step, count, full, dropped} !== {m_dir, m_step, m_count, m_full, m_dropped}) begin
                    failures++;
                    $display("[TB] FAIL random_cyc%0d actual dir=%b step=%b count=%0d full=%b dropped=%b required dir=%b step=%b count=%0d full=%b dropped=%b",
                             cyc, dir, step, count, full, dropped, m_dir, m_step, m_count, m_full, m_dropped);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_pop();
        test_sequence();
        test_full();
        test_multi_press();
        test_flush();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/snake_dir_queue.md
# snake_dir_queue

Direction-command buffer between the debounced button pulses and the snake game core. It accepts single-cycle Left/Right/Up/Down pulses (the SCEN outputs of the button debouncers), filters illegal or redundant commands, and stores up to DEPTH of them in a FIFO. On each game tick it pops one command and presents it as the snake's current heading. Fast key sequences (e.g. Up then Left within one game step) are therefore applied on successive steps instead of being lost.

## Interface
- DEPTH, 4, FIFO capacity in commands; power of two, 2..16
- CLK  in  1  single clock; all logic on rising edge
- Reset  in  1  synchronous, active-high; dominates all other inputs
- Left, Right, Up, Down  in  1 each  single-cycle command pulses
- Tick  in  1  one-cycle game-step strobe
- Flush  in  1  synchronous queue clear (game restart)
- Dir  out  2  current heading: 00 up, 01 right, 10 down, 11 left
- Step  out  1  one-cycle pulse; Dir is valid for the new step
- Count  out  $clog2(DEPTH)+1  queued command count
- Full  out  1  Count == DEPTH
- Dropped  out  1  one-cycle pulse: a command pulse was discarded

## Operation
- Reset values: Dir=01, internal last-accepted direction=01, Count=0, Full=0, Step=0, Dropped=0, read/write pointers=0.
- Decode: exactly one of Left/Right/Up/Down high gives a candidate. Two or more high in one cycle: no candidate, Dropped pulses.
- Reject the candidate with a Dropped pulse in any of these cases:
  - it equals last-accepted (duplicate);
  - it is the opposite of last-accepted (reversal; see Configuration);
  - the FIFO is full and Tick is not high in the same cycle.
- Accept: write the candidate at the write pointer, advance it (wraps mod DEPTH), Count+1, set last-accepted to the candidate.
- Tick with Count>0: Dir <= head entry, advance the read pointer (wraps), Count-1. Tick with Count=0: Dir unchanged.
- Step pulses on every Tick, whether or not a pop occurred.
- Accept and pop in the same cycle: Count unchanged. This is legal when full, because the pop frees the slot.
- Accept and pop in the same cycle with Count=0: no bypass. The command is enqueued and becomes Dir on the next Tick.
- Last-accepted equals Dir whenever the queue is empty. The filter therefore always compares against the newest committed or pending heading.
- Flush: same effect as Reset on every register except that it is not a reset (Dir=01, last-accepted=01, Count=0, pointers=0). Command pulses and Tick in a Flush cycle are ignored, and Dropped does not pulse.
- Priority: Reset > Flush > Tick/accept.

## Timing
- All outputs are registered. Effects of inputs sampled at edge N are visible after edge N.
- Pop latency: Tick sampled at edge N gives a new Dir and Step=1 in cycle N+1. Step lasts exactly one cycle.
- Accept latency: a pulse at edge N updates Count and Full after N. It can be popped at the earliest by a Tick at edge N+1.
- Dropped is high in the cycle after the offending pulse, for exactly one cycle.
- Back-to-back pulses on consecutive cycles are each evaluated against last-accepted as already updated by the previous cycle.
- Reset asserted mid-operation discards queued commands in the same edge. No Step or Dropped appears in the cycle after Reset.

## Configuration
- SNAKE_DIR_REVERSE_FILTER_EN defined: reversal candidates (opposite of last-accepted) are rejected with a Dropped pulse.
- Not defined: reversals are accepted and queued like any other command, and the game core handles self-collision. Duplicate, multi-press and full rejection are unaffected.

## Test plan
- Reset, then Up pulse, then Tick two cycles later: Count 0→1→0, Dir=00 and Step=1 in the cycle after Tick, Dropped stays 0.
- From Dir=01 (empty queue), pulse Up, Left, Down on consecutive cycles, then three Ticks: Dir goes 00, 11, 10. Pulse Right when last-accepted=11 (filter defined): Dropped=1 and Count unchanged. Same Right pulse with the filter undefined: accepted.
- DEPTH=4: alternate Up/Left for 5 accepted-legal pulses with no Tick: Full=1 after the 4th, 5th gives Dropped=1. Repeat with Tick coincident with the 5th: accepted, Count stays 4.
- Left and Up high in the same cycle: Dropped=1, Count unchanged. Right pulse at reset (duplicate of 01): Dropped=1.
- Queue 3 commands, assert Flush with a Down pulse in the same cycle: Count=0, Dir=01, Dropped=0. A following Tick gives Step=1 with Dir=01.
- Run 20 push/pop cycles to wrap the pointers past DEPTH: Dir sequence matches push order exactly. Reset mid-sequence: next cycle Count=0, Dir=01.
